// File: rtl/inst_encoder_loader.sv
// Packs decoder-compatible instruction fields into 8-bit words and streams them into
// instruction memory over a valid/ready load session with a one-cycle registered write.
module inst_encoder_loader #(
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic          in_fn,
    input  logic [1:0]    in_rs1,
    input  logic [1:0]    in_rs2,
    input  logic [3:0]    in_imm,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          err_undef,
    output logic          err_full
);

    localparam int DATA_W = 8;
    localparam logic [AW+1:0] DEPTH_V = (AW+2)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    logic                wr_vld_p1;
    logic [AW-1:0]       wr_addr_p1;
    logic [DATA_W-1:0]   wr_data_p1;
    logic [AW:0]         cnt;
    logic [AW+1:0]       inflight;
    logic                xfer;
    logic                is_undef;
    logic                full_hit;

    function automatic logic is_iform(input logic [2:0] op, input logic fn);
        return (op == 3'b001) || (op == 3'b101) || ((op == 3'b111) && !fn);
    endfunction

    function automatic logic [DATA_W-1:0] encode(input logic [2:0] op, input logic fn,
                                                 input logic [1:0] rs1, input logic [1:0] rs2,
                                                 input logic [3:0] imm);
        if (is_iform(op, fn))
            return {imm, fn, op};
        else
            return {rs1, rs2, fn, op};
    endfunction

    // Words written plus the one still in the write register; this is also the next address.
    assign inflight = {1'b0, cnt} + {{(AW+1){1'b0}}, wr_vld_p1};
    assign in_ready = (state == S_LOAD) && (inflight < DEPTH_V);
    assign xfer     = in_valid && in_ready;
    assign is_undef = (in_op == 3'b111) && in_fn;
    assign full_hit = (state == S_LOAD) && in_valid && !in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_undef  <= 1'b0;
            err_full   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Stage p1: registered memory write, one cycle after the accept
            wr_vld_p1 <= xfer && !is_undef;
            if (xfer && !is_undef) begin
                wr_addr_p1 <= inflight[AW-1:0];
                wr_data_p1 <= encode(in_op, in_fn, in_rs1, in_rs2, in_imm);
            end
            if (wr_vld_p1)
                cnt <= cnt + (AW+1)'(1);
            if (xfer && is_undef)
                err_undef <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        err_undef <= 1'b0;
                        err_full  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if ((xfer && in_last) || full_hit)
                        state <= S_DRAIN;
                    if (full_hit)
                        err_full <= 1'b1;
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_we    = wr_vld_p1;
    assign mem_addr  = wr_addr_p1;
    assign mem_wdata = wr_data_p1;
    assign count     = cnt;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed session scenarios plus randomized load sessions,
// checked every cycle against a session-level reference model.
module tb_inst_encoder_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic          in_fn;
    logic [1:0]    in_rs1;
    logic [1:0]    in_rs2;
    logic [3:0]    in_imm;
    logic          in_last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          err_undef;
    logic          err_full;

    inst_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_fn(in_fn), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .count(count), .err_undef(err_undef), .err_full(err_full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_done = 0;
    bit chk_en = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t wlog[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference encoding, written as field weights
    function automatic int enc(input int op, input int fn, input int r1, input int r2, input int im);
        bit iform;
        iform = (op == 1) || (op == 5) || (op == 7 && fn == 0);
        if (iform) return im * 16 + fn * 8 + op;
        return r1 * 64 + r2 * 16 + fn * 8 + op;
    endfunction

    // Session-level model: phase 0 idle, 1 loading, 2 draining, 3 done
    int m_phase   = 0;
    int m_acc     = 0;
    int m_written = 0;
    bit m_undef   = 0;
    bit m_full    = 0;
    bit m_we      = 0;
    int m_addr    = 0;
    int m_data    = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_acc = 0; m_written = 0;
                m_undef = 0; m_full = 0; m_we = 0;
            end else begin
                if (m_we) m_written++;
                m_we = 0;
                case (m_phase)
                    0: if (start) begin
                        m_phase = 1; m_acc = 0; m_written = 0; m_undef = 0; m_full = 0;
                    end
                    1: if (in_valid) begin
                        if (m_acc < DEPTH) begin
                            if (in_op == 3'd7 && in_fn) m_undef = 1;
                            else begin
                                m_we = 1;
                                m_addr = m_acc;
                                m_data = enc(int'(in_op), int'(in_fn), int'(in_rs1),
                                             int'(in_rs2), int'(in_imm));
                                m_acc++;
                            end
                            if (in_last) m_phase = 2;
                        end else begin
                            m_full = 1;
                            m_phase = 2;
                        end
                    end
                    2: m_phase = 3;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model, plus write log and done counter
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mem_we", int'(mem_we), int'(m_we));
                if (m_we && mem_we) begin
                    check("mem_addr", int'(mem_addr), m_addr);
                    check("mem_wdata", int'(mem_wdata), m_data);
                end
                check("in_ready", int'(in_ready), int'(m_phase == 1 && m_acc < DEPTH));
                check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
                check("done", int'(done), int'(m_phase == 3));
                check("count", int'(count), m_written);
                check("err_undef", int'(err_undef), int'(m_undef));
                check("err_full", int'(err_full), int'(m_full));
                if (mem_we) wlog.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
                if (done) n_done++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int op, input int fn, input int r1, input int r2, input int im,
                        input bit last, output bit acc);
        int w;
        w = 0;
        in_op = 3'(op); in_fn = 1'(fn); in_rs1 = 2'(r1); in_rs2 = 2'(r2);
        in_imm = 4'(im); in_last = last; in_valid = 1'b1;
        while (!in_ready && w < 4) begin
            tick();
            w++;
        end
        acc = in_ready;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) begin
            n_chk++;
            $display("FAIL idle_timeout: busy still 1, expected 0");
        end
        tick();
        tick();
    endtask

    initial begin
        bit acc;
        int d0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = '0; in_fn = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // T1: single NOR with last
        wlog.delete(); d0 = n_done;
        do_start();
        send(0, 1, 2, 2, 0, 1'b1, acc);
        check("t1_we", int'(mem_we), 1);
        check("t1_addr", int'(mem_addr), 0);
        check("t1_wdata", int'(mem_wdata), 'hA8);
        tick();
        check("t1_done", int'(done), 1);
        check("t1_count", int'(count), 1);
        wait_idle();
        check("t1_done_pulses", n_done - d0, 1);

        // T2: BLT then JMP back-to-back
        wlog.delete();
        do_start();
        send(1, 1, 0, 0, 'hA, 1'b0, acc);
        send(7, 0, 0, 0, 'hA, 1'b1, acc);
        wait_idle();
        check("t2_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("t2_a0", wlog[0].addr, 0);
            check("t2_d0", wlog[0].data, 'hA9);
            check("t2_a1", wlog[1].addr, 1);
            check("t2_d1", wlog[1].data, 'hA7);
            check("t2_gap", wlog[1].cyc - wlog[0].cyc, 1);
        end

        // T3: undefined tuple between two ADDs
        wlog.delete();
        do_start();
        send(3, 0, 1, 2, 0, 1'b0, acc);
        send(7, 1, 3, 3, 5, 1'b0, acc);
        send(3, 1, 2, 1, 0, 1'b1, acc);
        wait_idle();
        check("t3_nwr", wlog.size(), 2);
        if (wlog.size() == 2) check("t3_a1", wlog[1].addr, 1);
        check("t3_err_undef", int'(err_undef), 1);
        check("t3_count", int'(count), 2);

        // T4: five tuples, no last, memory of four words
        wlog.delete(); d0 = n_done;
        do_start();
        for (int i = 0; i < 4; i++) send(3, 0, i, 0, 0, 1'b0, acc);
        check("t4_ready_after4", int'(in_ready), 0);
        send(3, 0, 0, 1, 0, 1'b0, acc);
        check("t4_fifth_acc", int'(acc), 0);
        wait_idle();
        check("t4_nwr", wlog.size(), 4);
        if (wlog.size() == 4) check("t4_a3", wlog[3].addr, 3);
        check("t4_err_full", int'(err_full), 1);
        check("t4_count", int'(count), 4);
        check("t4_done_pulses", n_done - d0, 1);

        // T6: valid held in idle, then start
        wlog.delete();
        in_op = 3'd2; in_fn = 1'b0; in_rs1 = 2'd3; in_rs2 = 2'd1; in_imm = '0;
        in_last = 1'b1; in_valid = 1'b1;
        repeat (3) tick();
        check("t6_idle_nwr", wlog.size(), 0);
        check("t6_idle_ready", int'(in_ready), 0);
        do_start();
        check("t6_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        check("t6_we", int'(mem_we), 1);
        check("t6_wdata", int'(mem_wdata), 3 * 64 + 16 + 2);
        wait_idle();

        // T5: reset during a write
        do_start();
        send(3, 0, 1, 1, 0, 1'b0, acc);
        check("t5_we_before", int'(mem_we), 1);
        rst = 1'b1;
        #1;
        check("t5_we", int'(mem_we), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_count", int'(count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("t5_idle_busy", int'(busy), 0);
        check("t5_idle_ready", int'(in_ready), 0);

        // Randomized sessions
        for (int s = 0; s < 30; s++) begin
            bit use_last;
            int len, n;
            bit last;
            d0 = n_done;
            do_start();
            use_last = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            n = 0;
            forever begin
                last = (use_last && n == len - 1) || n == 30;
                send($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 15), last, acc);
                n++;
                if (!acc || last) break;
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle();
            check("rand_done_pulses", n_done - d0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
